// File: rtl/axi_lite_mbox_array_pkg.sv
// Shared definitions for the AXI-Lite mailbox array: register map, bit indices, FSM and config types.
// Also provides the default AXI-Lite request/response structs used when the top's type parameters are left alone.
package axi_lite_mbox_array_pkg;

  localparam int unsigned ChanStride = 32'h20;

  localparam logic [4:0] OFF_DATA     = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_THRESH   = 5'h08;
  localparam logic [4:0] OFF_IRQ_EN   = 5'h0C;
  localparam logic [4:0] OFF_IRQ_STAT = 5'h10;
  localparam logic [4:0] OFF_CTRL     = 5'h14;
  localparam logic [4:0] OFF_OVF_CNT  = 5'h18;

  localparam int STAT_EMPTY  = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_LVL_LO = 8;

  localparam int IRQ_THRESH = 0;
  localparam int IRQ_OVF    = 1;
  localparam int IRQ_UDF    = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} fsm_state_e;

  // sticky[0] is overflow, sticky[1] is underflow
  typedef struct packed {
    logic [7:0] thresh;
    logic [2:0] irq_en;
    logic [1:0] sticky;
  } chan_cfg_t;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } axi_lite_resp_t;

endpackage

// File: rtl/axi_lite_mbox_array_chan.sv
// One mailbox channel: word FIFO, THRESH/IRQ_EN/sticky registers and the registered IRQ.
// With MBOX_OVF_CNT_EN defined it also keeps an 8-bit saturating overflow-drop counter.
module axi_lite_mbox_array_chan
  import axi_lite_mbox_array_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  logic        i_threshWe,
  input  logic        i_irqEnWe,
  input  logic        i_w1cWe,
`ifdef MBOX_OVF_CNT_EN
  input  logic        i_ovfClr,
  output logic [7:0]  o_ovfCnt,
`endif
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_status,
  output logic [7:0]  o_thresh,
  output logic [2:0]  o_irqEn,
  output logic [2:0]  o_irqStat,
  output logic        o_irq
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     r_mem [Depth];
  logic [PtrW-1:0] r_wrPtr;
  logic [PtrW-1:0] r_rdPtr;
  logic [CntW-1:0] r_count;
  chan_cfg_t       r_cfg;
  logic            r_irq;

  logic       w_full;
  logic       w_empty;
  logic       w_above;
  logic [7:0] w_level;
  logic [1:0] w_stickySet;
  logic [1:0] w_stickyClr;
  logic [2:0] w_irqStat;

  assign w_full  = (r_count == CntW'(Depth));
  assign w_empty = (r_count == '0);
  assign w_level = (32'(r_count) > 32'd255) ? 8'hFF : 8'(r_count);
  assign w_above = (32'(r_count) > 32'(r_cfg.thresh));

  assign w_stickySet = {i_pop && w_empty, i_push && w_full};
  assign w_stickyClr = i_w1cWe ? i_wdata[IRQ_UDF:IRQ_OVF] : 2'b00;

  always_comb begin
    w_irqStat             = '0;
    w_irqStat[IRQ_THRESH] = w_above;
    w_irqStat[IRQ_OVF]    = r_cfg.sticky[0];
    w_irqStat[IRQ_UDF]    = r_cfg.sticky[1];
    o_status                     = '0;
    o_status[STAT_EMPTY]         = w_empty;
    o_status[STAT_FULL]          = w_full;
    o_status[STAT_LVL_LO +: 8]   = w_level;
  end

  assign o_rdata   = r_mem[r_rdPtr];
  assign o_thresh  = r_cfg.thresh;
  assign o_irqEn   = r_cfg.irq_en;
  assign o_irqStat = w_irqStat;
  assign o_irq     = r_irq;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (i_push && !w_full) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_push && !w_full) begin
      r_wrPtr <= r_wrPtr + 1'b1;
      r_count <= r_count + 1'b1;
    end else if (i_pop && !w_empty) begin
      r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  // Sticky set wins over a simultaneous W1C; flush leaves the sticky bits alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg <= '0;
      r_irq <= 1'b0;
    end else begin
      if (i_threshWe) r_cfg.thresh <= i_wdata[7:0];
      if (i_irqEnWe)  r_cfg.irq_en <= i_wdata[2:0];
      r_cfg.sticky <= (r_cfg.sticky & ~w_stickyClr) | w_stickySet;
      r_irq        <= |(w_irqStat & r_cfg.irq_en);
    end
  end

`ifdef MBOX_OVF_CNT_EN
  logic [7:0] r_ovfCnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovfCnt <= '0;
    end else if (i_ovfClr) begin
      r_ovfCnt <= '0;
    end else if (i_push && w_full && (r_ovfCnt != 8'hFF)) begin
      r_ovfCnt <= r_ovfCnt + 8'd1;
    end
  end

  assign o_ovfCnt = r_ovfCnt;
`endif

endmodule

// File: rtl/axi_lite_mbox_array.sv
// N-channel AXI4-Lite mailbox: address decode, single-outstanding handshake FSM and response muxing.
// Optional feature macro: MBOX_OVF_CNT_EN adds a per-channel overflow counter at offset 0x18.
module axi_lite_mbox_array
  import axi_lite_mbox_array_pkg::*;
#(
  parameter int unsigned          NumChannels = 4,
  parameter int unsigned          Depth       = 8,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [AddrWidth-1:0] BaseAddr    = 32'h1040_5000,
  parameter type                  req_lite_t  = axi_lite_req_t,
  parameter type                  resp_lite_t = axi_lite_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  req_lite_t              slv_req_i,
  output resp_lite_t             slv_resp_o,
  output logic [NumChannels-1:0] irq_o
);

  if (DataWidth != 32) begin : g_dataWidthCheck
    $fatal(1, "axi_lite_mbox_array: DataWidth must be 32");
  end

  fsm_state_e r_state;
  fsm_state_e w_stateNext;
  logic       r_prio;
  logic [1:0] r_bResp;
  logic [1:0] r_rResp;
  logic [31:0] r_rData;

  logic w_grantW;
  logic w_grantR;
  logic w_wrReq;

  logic [AddrWidth-1:0] w_addr;
  logic [AddrWidth-1:0] w_off;
  logic                 w_inWin;
  logic [3:0]           w_chan;
  logic [4:0]           w_reg;

  logic [NumChannels-1:0] w_sel;
  logic [NumChannels-1:0] w_push;
  logic [NumChannels-1:0] w_pop;
  logic [NumChannels-1:0] w_flush;
  logic [NumChannels-1:0] w_threshWe;
  logic [NumChannels-1:0] w_irqEnWe;
  logic [NumChannels-1:0] w_w1cWe;

  logic [31:0] w_chRdata   [NumChannels];
  logic [31:0] w_chStatus  [NumChannels];
  logic [7:0]  w_chThresh  [NumChannels];
  logic [2:0]  w_chIrqEn   [NumChannels];
  logic [2:0]  w_chIrqStat [NumChannels];

  logic [31:0] w_selHead;
  logic [31:0] w_selStatus;
  logic [7:0]  w_selThresh;
  logic [2:0]  w_selIrqEn;
  logic [2:0]  w_selIrqStat;
  logic [7:0]  w_selOvfCnt;
  logic        w_err;
  logic [31:0] w_rdata;

`ifdef MBOX_OVF_CNT_EN
  logic [NumChannels-1:0] w_ovfClr;
  logic [7:0]             w_chOvfCnt [NumChannels];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  // r_prio=0 lets a write win a same-cycle collision, 1 lets the read win.
  always_comb begin
    w_stateNext = r_state;
    w_grantW    = 1'b0;
    w_grantR    = 1'b0;
    w_wrReq     = slv_req_i.aw_valid && slv_req_i.w_valid;
    unique case (r_state)
      IDLE: begin
        w_grantW = w_wrReq && (!slv_req_i.ar_valid || !r_prio);
        w_grantR = slv_req_i.ar_valid && (!w_wrReq || r_prio);
        if (w_grantW)      w_stateNext = WRESP;
        else if (w_grantR) w_stateNext = RRESP;
      end
      WRESP: if (slv_req_i.b_ready) w_stateNext = IDLE;
      RRESP: if (slv_req_i.r_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = w_grantW;
    slv_resp_o.w_ready  = w_grantW;
    slv_resp_o.ar_ready = w_grantR;
    slv_resp_o.b_valid  = (r_state == WRESP);
    slv_resp_o.b_resp   = r_bResp;
    slv_resp_o.r_valid  = (r_state == RRESP);
    slv_resp_o.r_resp   = r_rResp;
    slv_resp_o.r_data   = r_rData;
  end

  assign w_addr  = w_grantW ? slv_req_i.aw_addr : slv_req_i.ar_addr;
  assign w_off   = w_addr - BaseAddr;
  assign w_inWin = (w_addr >= BaseAddr) &&
                   (w_off < AddrWidth'(NumChannels * ChanStride));
  assign w_chan  = w_off[8:5];
  assign w_reg   = {w_off[4:2], 2'b00};

  always_comb begin
    w_sel        = '0;
    w_push       = '0;
    w_pop        = '0;
    w_flush      = '0;
    w_threshWe   = '0;
    w_irqEnWe    = '0;
    w_w1cWe      = '0;
    w_selHead    = '0;
    w_selStatus  = '0;
    w_selThresh  = '0;
    w_selIrqEn   = '0;
    w_selIrqStat = '0;
    w_selOvfCnt  = '0;
`ifdef MBOX_OVF_CNT_EN
    w_ovfClr     = '0;
`endif
    for (int c = 0; c < NumChannels; c++) begin
      w_sel[c] = w_inWin && (w_chan == 4'(c));
      if (w_sel[c]) begin
        w_selHead    = w_chRdata[c];
        w_selStatus  = w_chStatus[c];
        w_selThresh  = w_chThresh[c];
        w_selIrqEn   = w_chIrqEn[c];
        w_selIrqStat = w_chIrqStat[c];
`ifdef MBOX_OVF_CNT_EN
        w_selOvfCnt  = w_chOvfCnt[c];
`endif
      end
      w_push[c]     = w_grantW && w_sel[c] && (w_reg == OFF_DATA) && (slv_req_i.w_strb == 4'hF);
      w_pop[c]      = w_grantR && w_sel[c] && (w_reg == OFF_DATA);
      w_flush[c]    = w_grantW && w_sel[c] && (w_reg == OFF_CTRL) && slv_req_i.w_data[0];
      w_threshWe[c] = w_grantW && w_sel[c] && (w_reg == OFF_THRESH);
      w_irqEnWe[c]  = w_grantW && w_sel[c] && (w_reg == OFF_IRQ_EN);
      w_w1cWe[c]    = w_grantW && w_sel[c] && (w_reg == OFF_IRQ_STAT);
`ifdef MBOX_OVF_CNT_EN
      w_ovfClr[c]   = w_grantW && w_sel[c] && (w_reg == OFF_OVF_CNT);
`endif
    end
  end

  // Errors only arise from the window check and from DATA accesses.
  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    if (!w_inWin) begin
      w_err = 1'b1;
    end else if (w_reg == OFF_DATA) begin
      if (w_grantW) begin
        w_err = (slv_req_i.w_strb != 4'hF) || w_selStatus[STAT_FULL];
      end else begin
        w_err   = w_selStatus[STAT_EMPTY];
        w_rdata = w_selStatus[STAT_EMPTY] ? 32'h0 : w_selHead;
      end
    end else begin
      case (w_reg)
        OFF_STATUS:   w_rdata = w_selStatus;
        OFF_THRESH:   w_rdata = {24'h0, w_selThresh};
        OFF_IRQ_EN:   w_rdata = {29'h0, w_selIrqEn};
        OFF_IRQ_STAT: w_rdata = {29'h0, w_selIrqStat};
        OFF_OVF_CNT:  w_rdata = {24'h0, w_selOvfCnt};
        default:      w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio  <= 1'b0;
      r_bResp <= RESP_OKAY;
      r_rResp <= RESP_OKAY;
      r_rData <= '0;
    end else begin
      if (w_grantW || w_grantR) r_prio <= ~r_prio;
      if (w_grantW) r_bResp <= w_err ? RESP_SLVERR : RESP_OKAY;
      if (w_grantR) begin
        r_rResp <= w_err ? RESP_SLVERR : RESP_OKAY;
        r_rData <= w_rdata;
      end
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    axi_lite_mbox_array_chan #(
      .Depth(Depth)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_push     (w_push[c]),
      .i_pop      (w_pop[c]),
      .i_flush    (w_flush[c]),
      .i_threshWe (w_threshWe[c]),
      .i_irqEnWe  (w_irqEnWe[c]),
      .i_w1cWe    (w_w1cWe[c]),
`ifdef MBOX_OVF_CNT_EN
      .i_ovfClr   (w_ovfClr[c]),
      .o_ovfCnt   (w_chOvfCnt[c]),
`endif
      .i_wdata    (slv_req_i.w_data),
      .o_rdata    (w_chRdata[c]),
      .o_status   (w_chStatus[c]),
      .o_thresh   (w_chThresh[c]),
      .o_irqEn    (w_chIrqEn[c]),
      .o_irqStat  (w_chIrqStat[c]),
      .o_irq      (irq_o[c])
    );
  end

endmodule

// File: tb/tb_axi_lite_mbox_array.sv
// Directed bench for axi_lite_mbox_array: scoreboard of expected responses checked with immediate assertions.
// Expectations for offset 0x18 follow MBOX_OVF_CNT_EN the same way the design does.
module tb_axi_lite_mbox_array;
  import axi_lite_mbox_array_pkg::*;

  localparam logic [31:0] Base = 32'h1040_5000;

  typedef struct {
    string       tag;
    logic [1:0]  resp;
    logic [31:0] data;
    bit          isRead;
  } exp_t;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  axi_lite_req_t  req;
  axi_lite_resp_t resp;
  logic [3:0]     irq;
  int             total = 0;
  int             bad = 0;
  exp_t           sbQ[$];

  always #5 clk_i = ~clk_i;

  axi_lite_mbox_array #(
    .NumChannels(4),
    .Depth      (8),
    .AddrWidth  (32),
    .DataWidth  (32),
    .BaseAddr   (Base),
    .req_lite_t (axi_lite_req_t),
    .resp_lite_t(axi_lite_resp_t)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .slv_req_i (req),
    .slv_resp_o(resp),
    .irq_o     (irq)
  );

  function automatic logic [31:0] chAddr(int c, logic [4:0] off);
    return Base + 32'(c) * 32'h20 + 32'(off);
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(string tag);
    total++;
    bad++;
    $error("[TB] FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  task automatic clearReq();
    req = '0;
  endtask

  task automatic applyStimulus(bit isRead, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    bit   got;
    exp_t e;
    @(posedge clk_i); #1;
    if (isRead) begin
      req.ar_addr  = addr;
      req.ar_valid = 1'b1;
    end else begin
      req.aw_addr  = addr;
      req.w_data   = data;
      req.w_strb   = strb;
      req.aw_valid = 1'b1;
      req.w_valid  = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = isRead ? resp.ar_ready : (resp.aw_ready && resp.w_ready);
    end
    @(posedge clk_i); #1;
    req.ar_valid = 1'b0;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    if (!got) begin
      timeoutFail("addr_handshake");
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = isRead ? resp.r_valid : resp.b_valid;
    end
    if (!got) begin
      timeoutFail("resp_valid");
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      return;
    end
    if (sbQ.size() == 0) begin
      timeoutFail("scoreboard_empty");
    end else begin
      e = sbQ.pop_front();
      if (isRead) begin
        checkOutput({e.tag, "_rresp"}, 32'(resp.r_resp), 32'(e.resp));
        checkOutput({e.tag, "_rdata"}, resp.r_data, e.data);
      end else begin
        checkOutput({e.tag, "_bresp"}, 32'(resp.b_resp), 32'(e.resp));
      end
    end
    req.r_ready = isRead;
    req.b_ready = !isRead;
    @(posedge clk_i); #1;
    req.r_ready = 1'b0;
    req.b_ready = 1'b0;
  endtask

  task automatic writeExp(string tag, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                          logic [1:0] r);
    exp_t e;
    e.tag = tag; e.resp = r; e.data = 32'h0; e.isRead = 1'b0;
    sbQ.push_back(e);
    applyStimulus(1'b0, addr, data, strb);
  endtask

  task automatic readExp(string tag, logic [31:0] addr, logic [1:0] r, logic [31:0] data);
    exp_t e;
    e.tag = tag; e.resp = r; e.data = data; e.isRead = 1'b1;
    sbQ.push_back(e);
    applyStimulus(1'b1, addr, 32'h0, 4'h0);
  endtask

  task automatic checkIrq(string tag, logic [3:0] exp);
    @(negedge clk_i);
    checkOutput(tag, 32'(irq), 32'(exp));
  endtask

  task automatic doReset();
    clearReq();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Write and read collide; the predicted winner is held for 5 cycles with the loser still valid.
  task automatic dualIssue(int rep, bit expW, logic [31:0] wdata, logic [31:0] rdataExp);
    exp_t e;
    e.tag = $sformatf("dual%0d", rep); e.resp = RESP_OKAY;
    e.data = expW ? 32'h0 : rdataExp; e.isRead = !expW;
    sbQ.push_back(e);
    @(posedge clk_i); #1;
    req.aw_addr  = chAddr(0, OFF_DATA);
    req.w_data   = wdata;
    req.w_strb   = 4'hF;
    req.ar_addr  = chAddr(0, OFF_STATUS);
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    req.ar_valid = 1'b1;
    @(negedge clk_i);
    checkOutput($sformatf("grant%0d", rep), {30'h0, resp.aw_ready, resp.ar_ready},
                expW ? 32'h2 : 32'h1);
    @(posedge clk_i); #1;
    if (expW) begin
      req.aw_valid = 1'b0;
      req.w_valid  = 1'b0;
    end else begin
      req.ar_valid = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput($sformatf("hold%0d_%0d", rep, i),
                  {30'h0, (expW ? resp.b_valid : resp.r_valid),
                          (expW ? resp.ar_ready : resp.aw_ready)}, 32'h2);
    end
    clearReq();
    @(negedge clk_i);
    e = sbQ.pop_front();
    if (expW) begin
      checkOutput({e.tag, "_bresp"}, 32'(resp.b_resp), 32'(e.resp));
      req.b_ready = 1'b1;
    end else begin
      checkOutput({e.tag, "_rresp"}, 32'(resp.r_resp), 32'(e.resp));
      checkOutput({e.tag, "_rdata"}, resp.r_data, e.data);
      req.r_ready = 1'b1;
    end
    @(posedge clk_i); #1;
    clearReq();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    clearReq();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_handshake", {27'h0, resp.aw_ready, resp.w_ready, resp.ar_ready,
                resp.b_valid, resp.r_valid}, 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    $display("[TB] step 1: FIFO order on ch0");
    for (int i = 1; i <= 8; i++)
      writeExp($sformatf("push0_%0d", i), chAddr(0, OFF_DATA), 32'hA5A5_0000 + 32'(i), 4'hF, RESP_OKAY);
    readExp("status0_full", chAddr(0, OFF_STATUS), RESP_OKAY, 32'h0000_0802);
    for (int i = 1; i <= 8; i++)
      readExp($sformatf("pop0_%0d", i), chAddr(0, OFF_DATA), RESP_OKAY, 32'hA5A5_0000 + 32'(i));
    readExp("status0_empty", chAddr(0, OFF_STATUS), RESP_OKAY, 32'h0000_0001);

    $display("[TB] step 2: overflow on ch1");
    for (int i = 0; i < 8; i++)
      writeExp($sformatf("push1_%0d", i), chAddr(1, OFF_DATA), 32'h1000 + 32'(i), 4'hF, RESP_OKAY);
    writeExp("push1_over", chAddr(1, OFF_DATA), 32'hDEAD, 4'hF, RESP_SLVERR);
    readExp("irqstat1", chAddr(1, OFF_IRQ_STAT), RESP_OKAY, 32'h3);
    checkIrq("irq1_disabled", 4'b0000);
    writeExp("irqen1", chAddr(1, OFF_IRQ_EN), 32'h2, 4'hF, RESP_OKAY);
    checkIrq("irq1_ovf", 4'b0010);
    writeExp("w1c1", chAddr(1, OFF_IRQ_STAT), 32'h2, 4'hF, RESP_OKAY);
    checkIrq("irq1_cleared", 4'b0000);
    readExp("irqstat1_after", chAddr(1, OFF_IRQ_STAT), RESP_OKAY, 32'h1);
`ifdef MBOX_OVF_CNT_EN
    readExp("ovfcnt1", chAddr(1, OFF_OVF_CNT), RESP_OKAY, 32'h1);
    writeExp("ovfcnt1_clr", chAddr(1, OFF_OVF_CNT), 32'h0, 4'hF, RESP_OKAY);
    readExp("ovfcnt1_zero", chAddr(1, OFF_OVF_CNT), RESP_OKAY, 32'h0);
`else
    readExp("ovfcnt1", chAddr(1, OFF_OVF_CNT), RESP_OKAY, 32'h0);
`endif
    readExp("status1_full", chAddr(1, OFF_STATUS), RESP_OKAY, 32'h0000_0802);

    $display("[TB] step 3: underflow, strobe and window errors");
    readExp("pop2_empty", chAddr(2, OFF_DATA), RESP_SLVERR, 32'h0);
    readExp("irqstat2", chAddr(2, OFF_IRQ_STAT), RESP_OKAY, 32'h4);
    writeExp("push2_strb", chAddr(2, OFF_DATA), 32'h55, 4'h3, RESP_SLVERR);
    readExp("status2", chAddr(2, OFF_STATUS), RESP_OKAY, 32'h0000_0001);
    writeExp("win_wr", Base + 32'h80, 32'h1, 4'hF, RESP_SLVERR);
    readExp("win_rd", Base + 32'h80, RESP_SLVERR, 32'h0);
    readExp("below_rd", Base - 32'h4, RESP_SLVERR, 32'h0);
    readExp("reserved_1c", chAddr(2, 5'h1C), RESP_OKAY, 32'h0);
    readExp("status0_still", chAddr(0, OFF_STATUS), RESP_OKAY, 32'h0000_0001);

    $display("[TB] step 4: threshold IRQ on ch3");
    writeExp("thresh3", chAddr(3, OFF_THRESH), 32'h2, 4'hF, RESP_OKAY);
    writeExp("irqen3", chAddr(3, OFF_IRQ_EN), 32'h1, 4'hF, RESP_OKAY);
    readExp("thresh3_rd", chAddr(3, OFF_THRESH), RESP_OKAY, 32'h2);
    writeExp("push3_0", chAddr(3, OFF_DATA), 32'h300, 4'hF, RESP_OKAY);
    writeExp("push3_1", chAddr(3, OFF_DATA), 32'h301, 4'hF, RESP_OKAY);
    checkIrq("irq3_at_thresh", 4'b0000);
    writeExp("push3_2", chAddr(3, OFF_DATA), 32'h302, 4'hF, RESP_OKAY);
    checkIrq("irq3_above", 4'b1000);
    readExp("pop3", chAddr(3, OFF_DATA), RESP_OKAY, 32'h300);
    checkIrq("irq3_fall", 4'b0000);
    writeExp("flush3", chAddr(3, OFF_CTRL), 32'h1, 4'hF, RESP_OKAY);
    readExp("status3_flushed", chAddr(3, OFF_STATUS), RESP_OKAY, 32'h0000_0001);
    readExp("ctrl3_rd", chAddr(3, OFF_CTRL), RESP_OKAY, 32'h0);

    $display("[TB] step 5: write/read arbitration");
    doReset();
    dualIssue(0, 1'b1, 32'hC0DE_0000, 32'h0);
    dualIssue(1, 1'b0, 32'hC0DE_0001, 32'h0000_0100);
    dualIssue(2, 1'b1, 32'hC0DE_0002, 32'h0);
    dualIssue(3, 1'b0, 32'hC0DE_0003, 32'h0000_0200);

    $display("[TB] step 6: reset during read response");
    writeExp("irqen1_r", chAddr(1, OFF_IRQ_EN), 32'h1, 4'hF, RESP_OKAY);
    writeExp("push1_r", chAddr(1, OFF_DATA), 32'h7777, 4'hF, RESP_OKAY);
    checkIrq("irq_before_rst", 4'b0010);
    @(posedge clk_i); #1;
    req.ar_addr  = chAddr(1, OFF_DATA);
    req.ar_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = resp.ar_ready;
    end
    @(posedge clk_i); #1;
    req.ar_valid = 1'b0;
    if (!got) timeoutFail("rst_ar_handshake");
    @(negedge clk_i);
    checkOutput("rvalid_before_rst", 32'(resp.r_valid), 32'h1);
    rst_ni = 1'b0;
    #1;
    checkOutput("rvalid_in_rst", 32'(resp.r_valid), 32'h0);
    checkOutput("irq_in_rst", 32'(irq), 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int c = 0; c < 4; c++)
      readExp($sformatf("status%0d_post_rst", c), chAddr(c, OFF_STATUS), RESP_OKAY, 32'h0000_0001);
    readExp("irqen1_post_rst", chAddr(1, OFF_IRQ_EN), RESP_OKAY, 32'h0);
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
